// File: rtl/rssb_datapath.sv
// RSSB datapath: PC, ACC and OP1 registers, reverse subtract, special memory locations.
// Optional memory-mapped I/O at addresses 3/4 is enabled by defining RSSB_IO_EN.
module rssb_datapath #(
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 8,
   parameter int RESET_PC = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel_pc,
   input  logic              sel_mem,
   input  logic              write_op1,
   input  logic              write_acc,
   input  logic              write_mem,
   input  logic              write_pc,
   output logic              neg,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] pc_o,
   output logic [WIDTH-1:0]  acc_o,
   input  logic [WIDTH-1:0]  io_in,
   output logic [WIDTH-1:0]  io_out,
   output logic              io_out_valid
);

   localparam logic [ADDR_W-1:0] ADDR_PC   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_ACC  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(2);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] op1;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  acc;
   logic [WIDTH-1:0]  rdval;
   logic [WIDTH-1:0]  result;
   logic              pc_load;
   logic              ram_space;

   assign addr = sel_mem ? pc : op1;

`ifdef RSSB_IO_EN
   localparam logic [ADDR_W-1:0] ADDR_IO_IN  = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_IO_OUT = ADDR_W'(4);

   logic io_wr;

   assign io_wr     = write_mem && (addr == ADDR_IO_OUT);
   assign ram_space = (addr > ADDR_ZERO) && (addr != ADDR_IO_OUT);
`else
   assign ram_space = addr > ADDR_ZERO;
`endif

   always_comb begin
      rdval = mem_rdata;
      case (addr)
         ADDR_PC:     rdval = WIDTH'(pc);
         ADDR_ACC:    rdval = acc;
         ADDR_ZERO:   rdval = '0;
`ifdef RSSB_IO_EN
         ADDR_IO_IN:  rdval = io_in;
         ADDR_IO_OUT: rdval = io_out;
`endif
         default:     rdval = mem_rdata;
      endcase
   end

   assign result    = rdval - acc;
   assign neg       = result[WIDTH-1];
   assign mem_wdata = result;
   assign pc_load   = write_mem && (addr == ADDR_PC);
   // NOTE: gating with rst keeps a half-finished instruction from reaching RAM during reset.
   assign mem_we    = write_mem && ram_space && !rst;
   assign mem_addr  = addr;
   assign pc_o      = pc;
   assign acc_o     = acc;

   // A write to address 0 is a jump and takes priority over the sequential increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc  <= ADDR_W'(RESET_PC);
         acc <= '0;
         op1 <= '0;
      end else begin
         if (pc_load)
            pc <= result[ADDR_W-1:0];
         else if (write_pc)
            pc <= pc + (sel_pc ? ADDR_W'(2) : ADDR_W'(1));
         if (write_acc)
            acc <= result;
         if (write_op1)
            op1 <= rdval[ADDR_W-1:0];
      end
   end

`ifdef RSSB_IO_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_out       <= '0;
         io_out_valid <= 1'b0;
      end else begin
         io_out_valid <= io_wr;
         if (io_wr)
            io_out <= result;
      end
   end
`else
   logic unused_io;

   assign io_out       = '0;
   assign io_out_valid = 1'b0;
   assign unused_io    = ^io_in;
`endif

endmodule

// File: tb/tb_rssb_datapath.sv
// Self-checking bench for rssb_datapath: behavioural model with per-cycle compare,
// directed scenarios with literal expectations, then randomized strobes.
module tb_rssb_datapath;

   localparam int unsigned WIDTH    = 16;
   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned RESET_PC = 5;
   localparam int unsigned WMOD     = 1 << WIDTH;
   localparam int unsigned AMOD     = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sel_pc = 1'b0, sel_mem = 1'b0, write_op1 = 1'b0;
   logic              write_acc = 1'b0, write_mem = 1'b0, write_pc = 1'b0;
   logic              neg, mem_we, io_out_valid;
   logic [ADDR_W-1:0] mem_addr, pc_o;
   logic [WIDTH-1:0]  mem_rdata, mem_wdata, acc_o, io_out;
   logic [WIDTH-1:0]  io_in = '0;

   bit   [WIDTH-1:0]  ram [AMOD];
   logic              poke_en = 1'b0;
   logic [ADDR_W-1:0] poke_addr = '0;
   logic [WIDTH-1:0]  poke_data = '0;

   int checks   = 0;
   int failures = 0;

   // Model state and expected combinational values for the current cycle.
   int unsigned m_pc, m_acc, m_op1, m_io_out, m_io_valid;
   int unsigned e_addr, e_rd, e_res;
   bit          e_neg, e_we;

   event do_check;

   rssb_datapath #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .sel_pc(sel_pc), .sel_mem(sel_mem),
      .write_op1(write_op1), .write_acc(write_acc), .write_mem(write_mem),
      .write_pc(write_pc), .neg(neg), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .pc_o(pc_o), .acc_o(acc_o),
      .io_in(io_in), .io_out(io_out), .io_out_valid(io_out_valid)
   );

   always #5 clk = ~clk;

   assign mem_rdata = ram[mem_addr];

   always @(posedge clk) begin
      if (mem_we)
         ram[mem_addr] <= mem_wdata;
      else if (poke_en)
         ram[poke_addr] <= poke_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_pc       = RESET_PC;
      m_acc      = 0;
      m_op1      = 0;
      m_io_out   = 0;
      m_io_valid = 0;
   endfunction

   function automatic int unsigned m_read(input int unsigned a);
      if (a == 0) return m_pc;
      if (a == 1) return m_acc;
      if (a == 2) return 0;
`ifdef RSSB_IO_EN
      if (a == 3) return 32'(io_in);
      if (a == 4) return m_io_out;
`endif
      return 32'(ram[a[ADDR_W-1:0]]);
   endfunction

   function automatic void model_eval();
      e_addr = sel_mem ? m_pc : m_op1;
      e_rd   = m_read(e_addr);
      e_res  = (e_rd + WMOD - m_acc) % WMOD;
      e_neg  = e_res >= WMOD / 2;
`ifdef RSSB_IO_EN
      e_we   = !rst && write_mem && e_addr > 2 && e_addr != 4;
`else
      e_we   = !rst && write_mem && e_addr > 2;
`endif
   endfunction

   function automatic void model_commit();
      if (rst) begin
         model_reset();
         return;
      end
      if (write_pc)
         m_pc = (m_pc + (sel_pc ? 2 : 1)) % AMOD;
      if (write_mem && e_addr == 0)
         m_pc = e_res % AMOD;
      if (write_acc)
         m_acc = e_res;
      if (write_op1)
         m_op1 = e_rd % AMOD;
`ifdef RSSB_IO_EN
      m_io_valid = (write_mem && e_addr == 4) ? 1 : 0;
      if (write_mem && e_addr == 4)
         m_io_out = e_res;
`endif
   endfunction

   always @(do_check) begin
      check("pc_o", 32'(pc_o), m_pc);
      check("acc_o", 32'(acc_o), m_acc);
      check("mem_addr", 32'(mem_addr), e_addr);
      check("mem_wdata", 32'(mem_wdata), e_res);
      check("neg", 32'(neg), 32'(e_neg));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("io_out", 32'(io_out), m_io_out);
      check("io_out_valid", 32'(io_out_valid), m_io_valid);
   end

   // Apply strobes at the falling edge; e1 makes sel_pc follow the expected sign.
   task automatic drive(input bit smem, input bit spc, input bit wop1, input bit wacc,
                        input bit wmem, input bit wpc, input bit e1);
      @(negedge clk);
      sel_mem   = smem;
      sel_pc    = spc;
      write_op1 = wop1;
      write_acc = wacc;
      write_mem = wmem;
      write_pc  = wpc;
      if (rst) model_reset();
      #1;
      model_eval();
      if (e1) sel_pc = e_neg;
      -> do_check;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_commit();
      poke_en = 1'b0;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic poke(input int unsigned a, input int unsigned d);
      poke_addr = ADDR_W'(a);
      poke_data = WIDTH'(d);
      poke_en   = 1'b1;
      idle();
   endtask

   task automatic set_op1(input int unsigned k);
      poke(m_pc, k);
      drive(1, 0, 1, 0, 0, 0, 0);
      tick();
   endtask

   task automatic set_acc(input int unsigned v);
      set_op1(1);
      drive(0, 0, 0, 1, 0, 0, 0);
      tick();
      poke(100, v);
      set_op1(100);
      drive(0, 0, 0, 1, 0, 0, 0);
      tick();
   endtask

   task automatic set_pc(input int unsigned t);
      set_acc((m_pc + WMOD - t) % WMOD);
      set_op1(0);
      drive(0, 0, 0, 0, 1, 0, 0);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      rst = 1'b0;
   endtask

   task automatic e1_drive();
      drive(0, 0, 0, 1, 1, 1, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();

      // Reset state, with fetch address selected.
      drive(1, 0, 0, 0, 0, 0, 0);
      check("rst_pc", 32'(pc_o), 5);
      check("rst_acc", 32'(acc_o), 0);
      check("rst_addr", 32'(mem_addr), 5);
      check("rst_we", 32'(mem_we), 0);
      tick();
      for (int i = 0; i < int'(AMOD); i++) poke(i, $urandom_range(WMOD - 1));
      rst = 1'b0;

      // Non-negative subtract.
      set_acc(3); poke(10, 7); set_op1(10);
      e1_drive();
      check("pos_wdata", 32'(mem_wdata), 4);
      check("pos_neg", 32'(neg), 0);
      check("pos_we", 32'(mem_we), 1);
      check("pos_addr", 32'(mem_addr), 10);
      tick();
      check("pos_acc", 32'(acc_o), 4);
      check("pos_pc", 32'(pc_o), 6);

      // Negative subtract skips.
      set_acc(5); poke(10, 2); set_op1(10);
      e1_drive();
      check("negc_wdata", 32'(mem_wdata), 32'hFFFD);
      check("negc_neg", 32'(neg), 1);
      tick();
      check("negc_pc", 32'(pc_o), 8);
      check("negc_acc", 32'(acc_o), 32'hFFFD);

      // Address 2 reads zero and is never written.
      set_acc(5); set_op1(2);
      e1_drive();
      check("zero_wdata", 32'(mem_wdata), 32'hFFFB);
      check("zero_we", 32'(mem_we), 0);
      tick();

      // Address 0 write is a jump, overriding sel_pc.
      set_pc(20);
      check("setpc", 32'(pc_o), 20);
      set_acc(4); set_op1(0);
      drive(0, 1, 0, 1, 1, 1, 0);
      check("jmp_wdata", 32'(mem_wdata), 16);
      check("jmp_we", 32'(mem_we), 0);
      tick();
      check("jmp_pc", 32'(pc_o), 16);

      // Address 1 reads ACC.
      set_op1(1);
      e1_drive();
      check("acc_wdata", 32'(mem_wdata), 0);
      check("acc_neg", 32'(neg), 0);
      tick();
      check("acc_acc", 32'(acc_o), 0);

      // PC wrap, skip and no-skip.
      set_pc(255); set_acc(1); poke(100, 0); set_op1(100);
      e1_drive();
      check("wrap2_neg", 32'(neg), 1);
      tick();
      check("wrap2_pc", 32'(pc_o), 1);
      do_reset();
      set_pc(255); set_acc(0); poke(100, 5); set_op1(100);
      e1_drive();
      tick();
      check("wrap1_pc", 32'(pc_o), 0);

      // Reset asserted in the middle of an E1 phase.
      do_reset();
      set_acc(3); poke(10, 7); set_op1(10);
      e1_drive();
      #2 rst = 1'b1;
      #1;
      check("midrst_pc", 32'(pc_o), 5);
      check("midrst_acc", 32'(acc_o), 0);
      check("midrst_we", 32'(mem_we), 0);
      check("midrst_addr", 32'(mem_addr), 0);
      model_reset();
      tick();
      rst = 1'b0;

`ifdef RSSB_IO_EN
      set_acc(2); set_op1(3);
      io_in = 16'd9;
      e1_drive();
      check("io_in_wdata", 32'(mem_wdata), 7);
      tick();
      set_acc(0); set_op1(4);
      e1_drive();
      check("io_out_we", 32'(mem_we), 0);
      check("io_out_wdata", 32'(mem_wdata), 0);
      tick();
      check("io_valid_hi", 32'(io_out_valid), 1);
      check("io_out_val", 32'(io_out), 0);
      idle();
      check("io_valid_lo", 32'(io_out_valid), 0);
`else
      set_acc(2); poke(3, 9); set_op1(3);
      io_in = 16'd1;
      e1_drive();
      check("ram3_wdata", 32'(mem_wdata), 7);
      check("ram3_we", 32'(mem_we), 1);
      tick();
      set_acc(0); set_op1(4);
      e1_drive();
      check("ram4_we", 32'(mem_we), 1);
      check("ram4_addr", 32'(mem_addr), 4);
      tick();
      check("ram4_valid", 32'(io_out_valid), 0);
`endif

      // Randomized strobes; the compare process checks every cycle.
      for (int i = 0; i < 2000; i++) begin
         int unsigned mode;
         mode  = $urandom_range(3);
         rst   = ($urandom_range(99) == 0);
         io_in = 16'($urandom);
         if (mode == 0)
            drive(1, 1'($urandom), 1, 0, 0, 0, 0);
         else if (mode == 1)
            e1_drive();
         else
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 0);
         tick();
         rst = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
